fetch_ctrl: RTL and testbench

Program-sequencing stage that sits directly upstream of the instruction ROM and decoder in `TopLevel`. It owns the program counter and the top-level `Start`/`Ack` handshake. It launches a program on a `Start` pulse, steps, branches or stalls the PC each cycle, and raises `Ack` when the decoder reports a halt. The PC freezes at the address of the halt instruction, so the bench can read the last executed instruction.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/fetch_ctrl.sv | 87 ++++++++
 tb/tb_fetch_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, default widths and helpers for the fetch/sequencing stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned OFS_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  // Sign-extends the low w bits of ofs to 32 bits; callers truncate to the PC width.
  function automatic logic signed [31:0] sext_ofs(input logic [31:0] ofs, input int unsigned w);
    logic signed [31:0] t;
    t = ofs << (32 - w);
    return t >>> (32 - w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program sequencer: owns the PC and the Start/Ack handshake, launches on the
// falling edge of Start and freezes the PC on the halt instruction.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned OFS_W = OFS_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             AbsJump,
  input  logic [PC_W-1:0]  AbsTarget,
  input  logic             RelJump,
  input  logic [OFS_W-1:0] RelOffset,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Run,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCnt
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rel_ofs;

  assign rel_ofs = PC_W'(sext_ofs(32'(RelOffset), OFS_W));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) state_d = ARM;
      end
      ARM: begin
        pc_d = '0;
        if (!Start) state_d = RUN;
      end
      RUN: begin
        // Stall masks everything, including a pending halt.
        if (Stall)        pc_d = pc_q;
        else if (Halt)    state_d = DONE;
        else if (AbsJump) pc_d = AbsTarget;
        else if (RelJump) pc_d = pc_q + rel_ofs;
        else              pc_d = pc_q + 1'b1;
      end
      DONE: begin
        if (Start) begin
          state_d = ARM;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Clearing on entry to ARM lets a relaunch from DONE show a zero count at once.
  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk (Clk),
    .rst (Reset),
    .clr (state_d == ARM),
    .en  (state_q == RUN),
    .cnt (CycleCnt)
  );

  assign ProgCtr = pc_q;
  assign Run     = (state_q == RUN);
  assign Ack     = (state_q == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a cycle-level reference model and literal checkpoints.
module tb_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, Start = 1'b0, Halt = 1'b0, Stall = 1'b0;
  logic       AbsJump = 1'b0, RelJump = 1'b0;
  logic [9:0] AbsTarget = '0;
  logic [7:0] RelOffset = '0;

  logic [9:0]  ProgCtr, ProgCtr4;
  logic        Run, Ack, Run4, Ack4;
  logic [15:0] CycleCnt;
  logic [3:0]  CycleCnt4;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .AbsJump(AbsJump), .AbsTarget(AbsTarget), .RelJump(RelJump), .RelOffset(RelOffset),
    .ProgCtr(ProgCtr), .Run(Run), .Ack(Ack), .CycleCnt(CycleCnt)
  );

  fetch_ctrl #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .AbsJump(AbsJump), .AbsTarget(AbsTarget), .RelJump(RelJump), .RelOffset(RelOffset),
    .ProgCtr(ProgCtr4), .Run(Run4), .Ack(Ack4), .CycleCnt(CycleCnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 running, 3 done.
  int  m_mode = 0, m_pc = 0, m_cnt = 0, m_cnt4 = 0, sofs;
  bit  chk_en = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      chk_en = 1'b1;
      m_mode = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (m_mode == 0) begin
      m_pc = 0;
      if (Start) begin m_mode = 1; m_cnt = 0; m_cnt4 = 0; end
    end else if (m_mode == 1) begin
      m_pc = 0; m_cnt = 0; m_cnt4 = 0;
      if (!Start) m_mode = 2;
    end else if (m_mode == 2) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      sofs = (RelOffset >= 8'd128) ? int'(RelOffset) - 256 : int'(RelOffset);
      if (Stall) m_pc = m_pc;
      else if (Halt) m_mode = 3;
      else if (AbsJump) m_pc = int'(AbsTarget);
      else if (RelJump) m_pc = ((m_pc + sofs) % 1024 + 1024) % 1024;
      else m_pc = (m_pc + 1) % 1024;
    end else if (Start) begin
      m_mode = 1; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
    end
    #1;
    if (chk_en) begin
      check("model_pc", 32'(ProgCtr), m_pc);
      check("model_run", 32'(Run), 32'(m_mode == 2));
      check("model_ack", 32'(Ack), 32'(m_mode == 3));
      check("model_cnt", 32'(CycleCnt), m_cnt);
      check("model_cnt4", 32'(CycleCnt4), m_cnt4);
      check("model_pc4", 32'(ProgCtr4), m_pc);
    end
  end

  task automatic step(input logic rst, input logic st, input logic ha, input logic sl,
                      input logic aj, input logic [9:0] tg, input logic rj, input logic [7:0] of);
    @(negedge Clk);
    Reset = rst; Start = st; Halt = ha; Stall = sl;
    AbsJump = aj; AbsTarget = tg; RelJump = rj; RelOffset = of;
    @(posedge Clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 10'd0, 0, 8'd0);
  endtask

  initial begin
    // Reset and launch
    step(1, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    step(1, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    check("reset_pc", 32'(ProgCtr), 32'd0);
    check("reset_run_ack", {30'd0, Run, Ack}, 32'd0);
    step(0, 1, 0, 0, 0, 10'd0, 0, 8'd0);
    check("arm_run", 32'(Run), 32'd0);
    step(0, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    check("launch_pc", 32'(ProgCtr), 32'd0);
    check("launch_run", 32'(Run), 32'd1);
    idle(5);
    check("seq_pc5", 32'(ProgCtr), 32'd5);
    // Branches
    step(0, 0, 0, 0, 0, 10'd0, 1, 8'hFD);
    check("rel_back3", 32'(ProgCtr), 32'd2);
    step(0, 0, 0, 0, 1, 10'h3FE, 0, 8'd0);
    check("abs_3fe", 32'(ProgCtr), 32'h3FE);
    idle(1);
    check("inc_3ff", 32'(ProgCtr), 32'h3FF);
    idle(1);
    check("wrap_0", 32'(ProgCtr), 32'h000);
    step(0, 0, 0, 0, 0, 10'd0, 1, 8'hFF);
    check("rel_wrap_back", 32'(ProgCtr), 32'h3FF);
    idle(2);
    check("pc1", 32'(ProgCtr), 32'd1);
    // Priority
    step(0, 0, 0, 0, 1, 10'd7, 1, 8'd4);
    check("abs_over_rel", 32'(ProgCtr), 32'd7);
    idle(2);
    step(0, 0, 1, 1, 0, 10'd0, 0, 8'd0);
    check("stall_halt_pc", 32'(ProgCtr), 32'd9);
    check("stall_halt_ack", 32'(Ack), 32'd0);
    step(0, 0, 1, 0, 0, 10'd0, 0, 8'd0);
    check("halt_ack", 32'(Ack), 32'd1);
    check("halt_pc", 32'(ProgCtr), 32'd9);
    // Relaunch, straight-line halt at 12
    step(0, 1, 0, 0, 0, 10'd0, 0, 8'd0);
    check("relaunch_ack", 32'(Ack), 32'd0);
    check("relaunch_pc", 32'(ProgCtr), 32'd0);
    check("relaunch_cnt", 32'(CycleCnt), 32'd0);
    step(0, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    idle(12);
    step(0, 0, 1, 0, 0, 10'd0, 0, 8'd0);
    check("halt12_pc", 32'(ProgCtr), 32'd12);
    check("halt12_cnt", 32'(CycleCnt), 32'd13);
    check("halt12_cnt4", 32'(CycleCnt4), 32'd13);
    // Same program with three stall cycles
    step(0, 1, 0, 0, 0, 10'd0, 0, 8'd0);
    step(0, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    idle(5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 10'd0, 0, 8'd0);
    idle(7);
    step(0, 0, 1, 0, 0, 10'd0, 0, 8'd0);
    check("stall_cnt", 32'(CycleCnt), 32'd16);
    check("sat_cnt4", 32'(CycleCnt4), 32'd15);
    idle(20);
    check("frozen_pc", 32'(ProgCtr), 32'd12);
    check("frozen_ack", 32'(Ack), 32'd1);
    check("frozen_cnt", 32'(CycleCnt), 32'd16);
    // Reset mid-run
    step(0, 1, 0, 0, 0, 10'd0, 0, 8'd0);
    step(0, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    idle(4);
    check("pre_reset_pc", 32'(ProgCtr), 32'd4);
    step(1, 0, 0, 0, 0, 10'd0, 0, 8'd0);
    check("midrun_reset", {20'd0, ProgCtr, Run, Ack}, 32'd0);
    idle(3);
    check("idle_after_reset", {20'd0, ProgCtr, Run, Ack}, 32'd0);
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
